ssd_driver: RTL
===============

SSD_DRIVER -- requirements
Module: ssd_driver

Interface
REQ-001 Parameter: REFRESH_DIV, default 100000, number of clk cycles each digit stays lit (legal range 2..2^20).
REQ-002 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 Port: value  input  13  unsigned binary number to display (0..8191), typically the datapath ssd output.
REQ-005 Port: Anode  output  4  digit enables, active-low; bit0 = rightmost digit (ones).
REQ-006 Port: LED_out  output  7  segment drives, active-low; LED_out[6]=a ... LED_out[0]=g.
REQ-007 Port: bcd  output  16  last completed conversion, 4 BCD nibbles; [15:12] = thousands.
REQ-008 Port: busy  output  1  high while a conversion is in SHIFT or LATCH.

Function
REQ-009 Converter FSM states: IDLE, SHIFT, LATCH; it runs continuously with no external start.
REQ-010 IDLE (1 cycle): capture value into a 13-bit shift register; clear the 16-bit scratch BCD; clear the 4-bit iteration counter; go to SHIFT.
REQ-011 SHIFT (exactly 13 cycles): add 3 to each scratch nibble that is >= 5, then shift {scratch, shift register} left by 1; after the 13th shift go to LATCH.
REQ-012 LATCH (1 cycle): copy scratch into bcd; go to IDLE.
REQ-013 Latency: bcd reflects a value sampled in IDLE exactly 15 cycles later (1 IDLE + 13 SHIFT + 1 LATCH); conversion period is 15 cycles.
REQ-014 Changes on value outside the IDLE sample cycle have no effect on the conversion in progress.
REQ-015 bcd never shows a partially converted result.
REQ-016 busy = 1 in SHIFT and LATCH; busy = 0 in IDLE.
REQ-017 Refresh counter counts 0..REFRESH_DIV-1 and wraps to 0.
REQ-018 On each wrap, the 2-bit digit index increments modulo 4 (3 -> 0).
REQ-019 Digit index to Anode: 0 -> 4'b1110 (bcd[3:0]); 1 -> 4'b1101 (bcd[7:4]); 2 -> 4'b1011 (bcd[11:8]); 3 -> 4'b0111 (bcd[15:12]).
REQ-020 Exactly one Anode bit is low at any time outside reset.
REQ-021 Segment encoding (abcdefg, active-low): 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
REQ-022 Any nibble value > 9 drives LED_out = 7'b1111111 (blank).
REQ-023 Anode and LED_out are registered: each clock they update from the current digit index and the current bcd.
REQ-024 A bcd update that coincides with a refresh wrap is displayed for the new digit on the following cycle; both events are honoured in the same edge.
REQ-025 No leading-zero blanking: 42 displays as 0042.

Reset
REQ-026 While rst = 0, asynchronously and with no clock edge required:
- Anode = 4'b1111, LED_out = 7'b1111111
- bcd = 16'h0000, busy = 0
- FSM = IDLE; refresh counter, digit index, iteration counter = 0
REQ-027 First rising edge after rst returns to 1:
- IDLE sample occurs
- Anode = 4'b1110, LED_out = 7'b0000001 (bcd still 0)
REQ-028 Reset asserted mid-conversion discards the conversion; bcd is not updated from the partial scratch.

Verification
REQ-029 Reset check: rst = 0 at any point -> Anode 4'b1111, LED_out 7'b1111111, bcd 16'h0000, busy 0 in the same timestep.
REQ-030 Conversion and latency: value = 1234, rst released -> bcd = 16'h1234 exactly 15 cycles after the first sample edge; busy high for 14 cycles; no intermediate bcd values.
REQ-031 Maximum value: value = 8191 -> bcd = 16'h8191; with the digit index at 3, LED_out = 7'b0000000.
REQ-032 Mid-conversion change: value = 42, switched to 99 on the 5th SHIFT cycle -> bcd goes 16'h0042 then 16'h0099 on the next conversion, with nothing in between.
REQ-033 Refresh and wrap, REFRESH_DIV = 4, value = 1234 after conversion completes:
- Anode sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles
- LED_out per digit: 4 = 1001100, 3 = 0000110, 2 = 0010010, 1 = 1001111
REQ-034 Reset mid-operation: rst pulsed low during SHIFT with value = 5678 -> immediate blank and bcd = 0; after release, bcd = 16'h5678 15 cycles after the first sample edge.

Source files
------------

// File: rtl/ssd_driver.sv
// Four-digit seven-segment driver: a continuously running double-dabble
// converter turns a 13-bit value into BCD, and a time-multiplexed scan lights one digit at a time.

module ssd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module ssd_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  Anode,
    output logic [6:0]  LED_out,
    output logic [15:0] bcd,
    output logic        busy
);
    localparam int NUM_DIGITS = 4;
    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t                           state, state_nx;
    logic [12:0]                      sr;
    logic [NUM_DIGITS-1:0][3:0]       scratch, adj;
    logic [3:0]                       iter;
    logic                             load, shift_en, latch_en;
    logic [CW-1:0]                    cnt;
    logic [1:0]                       idx;
    logic [3:0]                       nib;

    // per-digit +3 correction applied before every shift
    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
        ssd_add3 u_add3 (.din(scratch[g]), .dout(adj[g]));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = SHIFT;
            SHIFT:   if (iter == 4'd12) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        load     = (state == IDLE);
        shift_en = (state == SHIFT);
        latch_en = (state == LATCH);
        busy     = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr      <= '0;
            scratch <= '0;
            iter    <= '0;
        end else if (load) begin
            sr      <= value;
            scratch <= '0;
            iter    <= '0;
        end else if (shift_en) begin
            {scratch, sr} <= {adj[3][2:0], adj[2:0], sr, 1'b0};
            iter          <= iter + 4'd1;
        end
    end

    // bcd only ever takes a finished scratch, so the display never sees partial results
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          bcd <= '0;
        else if (latch_en) bcd <= scratch;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b0000001;
            4'd1:    seg7 = 7'b1001111;
            4'd2:    seg7 = 7'b0010010;
            4'd3:    seg7 = 7'b0000110;
            4'd4:    seg7 = 7'b1001100;
            4'd5:    seg7 = 7'b0100100;
            4'd6:    seg7 = 7'b0100000;
            4'd7:    seg7 = 7'b0001111;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0000100;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    assign nib = bcd[{idx, 2'b00} +: 4];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            Anode   <= 4'b1111;
            LED_out <= 7'b1111111;
        end else begin
            Anode   <= ~(4'b0001 << idx);
            LED_out <= seg7(nib);
        end
    end
endmodule
